// File: rtl/i2s_transmitter.sv
// I2S serialiser: derives BCLK/LRCLK from clk and shifts out one double-buffered
// left/right pair per frame, MSB first with the standard one-bit delay.
module i2s_transmitter #(
    parameter int WIDTH     = 24,
    parameter int SLOT_BITS = 32,
    parameter int BCLK_DIV  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_left,
    input  logic [WIDTH-1:0] in_right,
    output logic             bclk,
    output logic             lrclk,
    output logic             sdata,
    output logic             underrun
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int BW         = $clog2(FRAME_BITS);
    localparam int DW         = $clog2(BCLK_DIV);

    localparam logic [DW-1:0] DIV_LAST    = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF    = DW'(BCLK_DIV / 2);
    localparam logic [BW-1:0] BIT_LAST    = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0] LEFT_LAST   = BW'(WIDTH);
    localparam logic [BW-1:0] SLOT_START  = BW'(SLOT_BITS);
    localparam logic [BW-1:0] RIGHT_FIRST = BW'(SLOT_BITS + 1);
    localparam logic [BW-1:0] RIGHT_LAST  = BW'(SLOT_BITS + WIDTH);

    logic [DW-1:0]    div_cnt;
    logic [BW-1:0]    bit_cnt;
    logic             staging_full;
    logic [WIDTH-1:0] stage_left;
    logic [WIDTH-1:0] stage_right;
    logic [WIDTH-1:0] shift_left;
    logic [WIDTH-1:0] shift_right;

    logic             tick;
    logic             boundary;
    logic             accept;
    logic [DW-1:0]    div_next;
    logic [BW-1:0]    bit_next;
    logic             left_slot;
    logic             right_slot;

    // Slot decode is done on the post-tick bit index so lrclk/sdata land with bit_cnt.
    always_comb begin
        tick       = (div_cnt == DIV_LAST);
        boundary   = tick && (bit_cnt == BIT_LAST);
        accept     = in_valid && !staging_full;
        div_next   = tick ? '0 : div_cnt + DW'(1);
        bit_next   = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
        left_slot  = (bit_next != '0) && (bit_next <= LEFT_LAST);
        right_slot = (bit_next >= RIGHT_FIRST) && (bit_next <= RIGHT_LAST);
    end

    assign in_ready = ~staging_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt      <= '0;
            bit_cnt      <= '0;
            bclk         <= 1'b0;
            lrclk        <= 1'b0;
            sdata        <= 1'b0;
            underrun     <= 1'b0;
            staging_full <= 1'b0;
            stage_left   <= '0;
            stage_right  <= '0;
            shift_left   <= '0;
            shift_right  <= '0;
        end else begin
            div_cnt  <= div_next;
            bclk     <= (div_next >= DIV_HALF);
            underrun <= boundary && !staging_full;

            if (tick) begin
                bit_cnt <= bit_next;
                lrclk   <= (bit_next >= SLOT_START);
                if (left_slot)
                    sdata <= shift_left[WIDTH-1];
                else if (right_slot)
                    sdata <= shift_right[WIDTH-1];
                else
                    sdata <= 1'b0;

                // An empty staging buffer at the boundary plays a silent frame.
                if (boundary) begin
                    shift_left  <= staging_full ? stage_left  : '0;
                    shift_right <= staging_full ? stage_right : '0;
                end else begin
                    if (left_slot)
                        shift_left <= shift_left << 1;
                    if (right_slot)
                        shift_right <= shift_right << 1;
                end
            end

            // A full buffer drains at the boundary; ready is low then, so no capture clash.
            if (boundary && staging_full) begin
                staging_full <= 1'b0;
            end else if (accept) begin
                staging_full <= 1'b1;
                stage_left   <= in_left;
                stage_right  <= in_right;
            end
        end
    end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: two configurations driven by shared stimulus and checked
// every cycle against a frame-level model, plus literal expectations on key bits.
module tb_i2s_transmitter;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [23:0] in_left;
    logic [23:0] in_right;

    logic in_ready_a, bclk_a, lrclk_a, sdata_a, underrun_a;
    logic in_ready_b, bclk_b, lrclk_b, sdata_b, underrun_b;

    i2s_transmitter #(.WIDTH(24), .SLOT_BITS(32), .BCLK_DIV(4)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_left(in_left), .in_right(in_right), .bclk(bclk_a), .lrclk(lrclk_a),
        .sdata(sdata_a), .underrun(underrun_a)
    );

    i2s_transmitter #(.WIDTH(24), .SLOT_BITS(25), .BCLK_DIV(2)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_left(in_left), .in_right(in_right), .bclk(bclk_b), .lrclk(lrclk_b),
        .sdata(sdata_b), .underrun(underrun_b)
    );

    int checks = 0;
    int errors = 0;

    // Model state: k = clk edges since reset, plus per-instance staged and playing pairs.
    int          k = 0;
    bit          model_live = 1'b0;
    bit          staged [2];
    logic [23:0] st_l [2];
    logic [23:0] st_r [2];
    logic [23:0] cur_l [2];
    logic [23:0] cur_r [2];
    bit          ur [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int divOf(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    function automatic int slotOf(input int i);
        return (i == 0) ? 32 : 25;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (k=%0d)", name, actual, expected, k);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [23:0] l, input logic [23:0] r);
        in_valid = v;
        in_left  = l;
        in_right = r;
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Transaction-level frame model, advanced once per clk edge.
    always @(posedge clk) begin
        if (reset) begin
            k = 0;
            model_live = 1'b1;
            for (int i = 0; i < 2; i++) begin
                staged[i] = 1'b0;
                st_l[i] = '0;
                st_r[i] = '0;
                cur_l[i] = '0;
                cur_r[i] = '0;
                ur[i] = 1'b0;
            end
        end else if (model_live) begin
            for (int i = 0; i < 2; i++) begin
                int fd;
                bit acc;
                fd = 2 * slotOf(i) * divOf(i);
                acc = in_valid && !staged[i];
                ur[i] = 1'b0;
                if ((k % fd) == fd - 1) begin
                    if (staged[i]) begin
                        cur_l[i] = st_l[i];
                        cur_r[i] = st_r[i];
                        staged[i] = 1'b0;
                    end else begin
                        cur_l[i] = '0;
                        cur_r[i] = '0;
                        ur[i] = 1'b1;
                    end
                end
                if (acc) begin
                    staged[i] = 1'b1;
                    st_l[i] = in_left;
                    st_r[i] = in_right;
                end
            end
            k++;
        end
    end

    // Expected {bclk, lrclk, sdata, underrun, in_ready} after k edges.
    function automatic logic [4:0] expectOut(input int i);
        int d;
        int s;
        int b;
        logic bc;
        logic lr;
        logic sd;
        d  = divOf(i);
        s  = slotOf(i);
        b  = (k / d) % (2 * s);
        bc = ((k % d) >= d / 2);
        lr = (b >= s);
        sd = 1'b0;
        if (b >= 1 && b <= 24)
            sd = cur_l[i][24 - b];
        else if (b >= s + 1 && b <= s + 24)
            sd = cur_r[i][s + 24 - b];
        return {bc, lr, sd, ur[i], !staged[i]};
    endfunction

    always @(negedge clk) begin
        if (model_live) begin
            checkOutput("cycle_dut_a", 64'({bclk_a, lrclk_a, sdata_a, underrun_a, in_ready_a}), 64'(expectOut(0)));
            checkOutput("cycle_dut_b", 64'({bclk_b, lrclk_b, sdata_b, underrun_b, in_ready_b}), 64'(expectOut(1)));
        end
    end

    logic [3:0]  pat_a;
    logic [3:0]  pat_b;
    logic [63:0] f_a;
    logic [63:0] exp_a;
    logic [49:0] f_b;
    logic [49:0] exp_b;
    logic [23:0] w_l1, w_r1, w_l2, w_r2;
    logic [23:0] rl, rr;

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, '0, '0);
        @(negedge clk);
        doReset();

        // Idle after reset: clock shapes, word select and underrun timing.
        pat_a = 4'b1100;
        pat_b = 4'b1010;
        for (int t = 0; t <= 256; t++) begin
            if (t < 4) begin
                checkOutput("idle_bclk_a", 64'(bclk_a), 64'(pat_a[t]));
                checkOutput("idle_bclk_b", 64'(bclk_b), 64'(pat_b[t]));
            end
            if (t == 127) checkOutput("idle_lrclk_a_left", 64'(lrclk_a), 64'(1'b0));
            if (t == 128) checkOutput("idle_lrclk_a_right", 64'(lrclk_a), 64'(1'b1));
            if (t == 49)  checkOutput("idle_lrclk_b_left", 64'(lrclk_b), 64'(1'b0));
            if (t == 50)  checkOutput("idle_lrclk_b_right", 64'(lrclk_b), 64'(1'b1));
            if (t == 0 || t == 255) checkOutput("idle_no_underrun_a", 64'(underrun_a), 64'(1'b0));
            if (t == 256) checkOutput("idle_underrun_a", 64'(underrun_a), 64'(1'b1));
            if (t == 99)  checkOutput("idle_no_underrun_b", 64'(underrun_b), 64'(1'b0));
            if (t == 100) checkOutput("idle_underrun_b", 64'(underrun_b), 64'(1'b1));
            @(negedge clk);
        end

        // Single pair accepted in frame 0, plays in frame 1.
        doReset();
        applyStimulus(1'b1, 24'h800001, 24'h7FFFFE);
        @(negedge clk);
        checkOutput("single_ready_low", 64'(in_ready_a), 64'(1'b0));
        applyStimulus(1'b0, '0, '0);
        f_a = '0;
        f_b = '0;
        for (int t = 1; t < 512; t++) begin
            if (t >= 256 && (t % 4) == 2) f_a[63 - (t - 256) / 4] = sdata_a;
            if (t >= 100 && t < 200 && (t % 2) == 1) f_b[49 - (t - 100) / 2] = sdata_b;
            if (t == 256) checkOutput("single_no_underrun_a", 64'(underrun_a), 64'(1'b0));
            if (t == 100) checkOutput("single_no_underrun_b", 64'(underrun_b), 64'(1'b0));
            @(negedge clk);
        end
        exp_a = {1'b0, 24'h800001, 7'b0, 1'b0, 24'h7FFFFE, 7'b0};
        exp_b = {1'b0, 24'h800001, 1'b0, 24'h7FFFFE};
        checkOutput("single_frame_a", f_a, exp_a);
        checkOutput("single_frame_b", 64'(f_b), 64'(exp_b));

        // Backpressure: A taken at once, B waits for the boundary.
        doReset();
        applyStimulus(1'b1, 24'h13579B, 24'h2468AC);
        @(negedge clk);
        applyStimulus(1'b1, 24'hFEDCBA, 24'h0F0F0F);
        for (int t = 1; t < 768; t++) begin
            if (t == 255) checkOutput("bp_ready_low_boundary", 64'(in_ready_a), 64'(1'b0));
            if (t == 256) checkOutput("bp_ready_after_boundary", 64'(in_ready_a), 64'(1'b1));
            if (t == 257) begin
                checkOutput("bp_b_accepted", 64'(in_ready_a), 64'(1'b0));
                applyStimulus(1'b0, '0, '0);
            end
            if (t == 512) checkOutput("bp_no_underrun_f2", 64'(underrun_a), 64'(1'b0));
            if ((t % 4) == 2 && t >= 256) begin
                int b;
                b = ((t - 256) / 4) % 64;
                if (b >= 1 && b <= 24) begin
                    if (t < 512) w_l1[24 - b] = sdata_a;
                    else         w_l2[24 - b] = sdata_a;
                end
                if (b >= 33 && b <= 56 && t >= 512) w_r2[56 - b] = sdata_a;
            end
            @(negedge clk);
        end
        checkOutput("bp_frame1_left_a", 64'(w_l1), 64'(24'h13579B));
        checkOutput("bp_frame2_left_b", 64'(w_l2), 64'(24'hFEDCBA));
        checkOutput("bp_frame2_right_b", 64'(w_r2), 64'(24'h0F0F0F));

        // Handshake in the boundary cycle with staging empty.
        doReset();
        for (int t = 0; t < 768; t++) begin
            if (t == 255) applyStimulus(1'b1, 24'h123456, 24'h654321);
            if (t == 256) begin
                applyStimulus(1'b0, '0, '0);
                checkOutput("bnd_underrun", 64'(underrun_a), 64'(1'b1));
                checkOutput("bnd_staged", 64'(in_ready_a), 64'(1'b0));
            end
            if ((t % 4) == 2 && t >= 256) begin
                int b;
                b = ((t - 256) / 4) % 64;
                if (b >= 1 && b <= 24) begin
                    if (t < 512) w_l1[24 - b] = sdata_a;
                    else         w_l2[24 - b] = sdata_a;
                end
                if (b >= 33 && b <= 56) begin
                    if (t < 512) w_r1[56 - b] = sdata_a;
                    else         w_r2[56 - b] = sdata_a;
                end
            end
            @(negedge clk);
        end
        checkOutput("bnd_frame1_left_zero", 64'(w_l1), 64'(24'h0));
        checkOutput("bnd_frame1_right_zero", 64'(w_r1), 64'(24'h0));
        checkOutput("bnd_frame2_left", 64'(w_l2), 64'(24'h123456));
        checkOutput("bnd_frame2_right", 64'(w_r2), 64'(24'h654321));

        // Reset mid-frame with a pair staged: the pair must vanish.
        doReset();
        applyStimulus(1'b1, 24'hABCDEF, 24'h0FEDCB);
        @(negedge clk);
        applyStimulus(1'b0, '0, '0);
        repeat (41) @(negedge clk);
        checkOutput("mid_pre_bclk_high", 64'(bclk_a), 64'(1'b1));
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mid_reset_outputs", 64'({bclk_a, lrclk_a, sdata_a, underrun_a}), 64'(4'b0000));
        checkOutput("mid_reset_ready", 64'(in_ready_a), 64'(1'b1));
        reset = 1'b0;
        f_a = '0;
        for (int t = 0; t < 520; t++) begin
            if (t == 256) checkOutput("mid_underrun_f1", 64'(underrun_a), 64'(1'b1));
            if (t >= 256 && t < 512 && (t % 4) == 2) f_a[63 - (t - 256) / 4] = sdata_a;
            @(negedge clk);
        end
        checkOutput("mid_frame1_silent", f_a, 64'h0);

        // Random traffic with occasional resets, checked by the model each cycle.
        for (int n = 0; n < 4000; n++) begin
            rl = 24'($urandom);
            rr = 24'($urandom);
            applyStimulus($urandom_range(0, 7) == 0, rl, rr);
            reset = ($urandom_range(0, 1999) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        applyStimulus(1'b0, '0, '0);
        repeat (8) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_transmitter.md
# i2s_transmitter

- Serialises processed 24-bit stereo samples from the pedal DSP chain into a standard I2S stream for the output DAC. It is the output-side counterpart of the codec capture path.
- Generates its own bit clock and word-select from the system clock.
- Accepts one left/right pair per frame through a valid/ready handshake.
- Double-buffers the pair so the DSP pipeline sees a full frame of slack.

## Interface
Parameters:
- WIDTH, 24, sample width in bits (two's complement).
- SLOT_BITS, 32, BCLK periods per channel slot. Must satisfy SLOT_BITS ≥ WIDTH+1.
- BCLK_DIV, 4, clk cycles per BCLK period. Even, ≥ 2.

Ports:
- clk  in  1  system clock. All logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  sample pair on in_left/in_right is valid.
- in_ready  out  1  staging buffer empty. Transfer occurs when in_valid && in_ready.
- in_left  in  WIDTH  left sample.
- in_right  in  WIDTH  right sample.
- bclk  out  1  I2S bit clock, registered.
- lrclk  out  1  I2S word select: 0 = left, 1 = right. Registered.
- sdata  out  1  I2S serial data, MSB first, registered.
- underrun  out  1  one-clk pulse when a frame starts with no staged sample.

## Operation

**Divider**
- div_cnt counts 0..BCLK_DIV-1 and wraps.
- bclk = 0 while div_cnt < BCLK_DIV/2, otherwise 1. It is registered, so it is aligned to div_cnt.
- A "tick" is the cycle with div_cnt == BCLK_DIV-1. The following edge is the BCLK falling edge.

**Bit counter**
- bit_cnt counts 0..2·SLOT_BITS-1 and advances by 1 on each tick, wrapping.
- lrclk, sdata and bit_cnt all update on the same tick edge. Data therefore changes on BCLK falling edges and is stable at rising edges.

**Frame layout (by new bit_cnt value)**
- 0: lrclk=0, sdata=0 (I2S one-bit delay).
- 1..WIDTH: left[WIDTH-1..0].
- WIDTH+1..SLOT_BITS-1: 0.
- SLOT_BITS: lrclk=1, sdata=0.
- SLOT_BITS+1..SLOT_BITS+WIDTH: right[WIDTH-1..0].
- Remaining bits: 0.

**Buffering**
- The staging register holds {left, right} plus a staging_full flag. in_ready = ~staging_full.
- The shift register holds the pair currently being transmitted.

**Frame boundary** (tick with bit_cnt == 2·SLOT_BITS-1):
- If staging_full: copy staging to shift and clear staging_full.
- Otherwise: load the shift register with zeros and pulse underrun for that one edge.

**Boundary conditions**
- Handshake in a boundary cycle while staging was empty: the sample is captured into staging. The boundary still sees the pre-edge empty state, so the frame is zeros plus underrun, and the sample plays next frame.
- A boundary with staging full has in_ready=0 in that cycle. in_ready returns to 1 on the following cycle.
- in_valid without in_ready: nothing happens. in_left/in_right are ignored.
- Sample values are transmitted verbatim. There is no saturation or width conversion.

**Reset** (any cycle, mid-frame included)
- div_cnt=0, bit_cnt=0, bclk=0, lrclk=0, sdata=0, underrun=0, staging_full=0 (in_ready=1), shift register=0.
- Any staged or partly transmitted sample is discarded.
- The first frame after reset transmits zeros. Its start is not flagged as an underrun.
- The first load happens at the first boundary.

## Timing
- BCLK period is BCLK_DIV clk. Frame length is 2·SLOT_BITS·BCLK_DIV clk (256 with defaults).
- After reset release, the first tick is at clk cycle BCLK_DIV-1. The first boundary is at cycle 2·SLOT_BITS·BCLK_DIV-1.
- Latency from a staged pair being loaded at a boundary to left MSB on sdata is BCLK_DIV clk after the boundary edge (bit_cnt=1).
- Latency from acceptance to transmission is up to one frame, plus the boundary.
- in_ready rises exactly one clk after the boundary edge that emptied staging.

## Test plan
- **Reset / idle:** release reset, hold in_valid=0.
  - Required: bclk toggles with a 4-clk period (2 low, 2 high).
  - Required: lrclk is 0 for 128 clk, then 1 for 128 clk.
  - Required: sdata is 0 throughout.
  - Required: no underrun in frame 0, then one underrun pulse at each boundary from clk 255 onward.
- **Single pair:** accept left=0x800001, right=0x7FFFFE during frame 0.
  - Required: sampled at BCLK rises in frame 1, bits 1..24 = 1000…0001 and bits 33..56 = 0111…1110.
  - Required: all other bits are 0 and there is no underrun at that boundary.
- **Backpressure:** hold in_valid=1 with pair A then pair B.
  - Required: A is accepted at once and in_ready stays 0 until the boundary. B is accepted one clk after the boundary.
  - Required: A plays in frame 1 and B plays in frame 2.
- **Boundary-cycle handshake:** staging empty, in_valid asserted only in the boundary cycle with 0x123456/0x654321.
  - Required: that frame is zeros with an underrun pulse, and the pair plays in the next frame.
- **Mid-frame reset:** with a pair staged, assert reset at bit_cnt=10 for 1 clk.
  - Required: all outputs are at their reset values on the next edge and in_ready=1.
  - Required: the staged pair is never transmitted.
- **BCLK_DIV=2, SLOT_BITS=25:**
  - Required: bclk period is 2 clk and the frame is 100 clk.
  - Required: left LSB at bit 24, right MSB at bit 26, with no padding bits.
